// File: rtl/pin_checker_pkg.sv
// Shared types for the PIN checker: the assembler's packet format, checker states
// and the packet completeness test.
package pin_checker_pkg;

  localparam logic [3:0] PIN_BLANK_DIGIT = 4'hF;

  typedef struct packed {
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic       status;
  } pinPac_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StLockout,
    StProgWait,
    StProgStore
  } chk_state_e;

  // A digit left blank by the assembler makes the whole packet unusable.
  function automatic logic pin_complete(input logic [15:0] pin);
    return (pin[15:12] != PIN_BLANK_DIGIT) && (pin[11:8] != PIN_BLANK_DIGIT) &&
           (pin[7:4] != PIN_BLANK_DIGIT) && (pin[3:0] != PIN_BLANK_DIGIT);
  endfunction

endpackage

// File: rtl/pin_down_timer.sv
// Loadable down-counter; holds at zero once expired. Shared by lockout and
// PIN-programming windows.
module pin_down_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pin_checker.sv
// Compares submitted PINs against the stored PIN, pulses grant/deny, enforces a
// timed lockout after repeated failures and supports changing the stored PIN.
module pin_checker
  import pin_checker_pkg::*;
#(
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned LOCK_CYCLES  = 50_000_000,
  parameter int unsigned PROG_TIMEOUT = 250_000_000,
  parameter logic [15:0] DEFAULT_PIN  = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  pinPac_t    pin_in,
  input  logic       prog_req,
  output logic       grant,
  output logic       deny,
  output logic       prog_done,
  output logic       prog_active,
  output logic       locked,
  output logic [3:0] fail_count
);

  localparam int unsigned TimerMax = (LOCK_CYCLES > PROG_TIMEOUT) ? LOCK_CYCLES : PROG_TIMEOUT;
  localparam int unsigned TimerW   = $clog2(TimerMax);
  localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] ProgLoad = TimerW'(PROG_TIMEOUT - 1);
  localparam logic [3:0]        MaxFails = 4'(MAX_FAILS);

  chk_state_e  state_q, state_d;
  logic        status_q;
  logic [15:0] cand_q, cand_d;
  logic [15:0] stored_q, stored_d;
  logic [3:0]  fail_q, fail_d;
  logic        grant_q, grant_d;
  logic        deny_q, deny_d;
  logic        prog_done_q, prog_done_d;
  logic        tmr_load, tmr_zero;
  logic [TimerW-1:0] tmr_load_val;
  logic        sub;
  logic [15:0] pin_digits;

  // The assembler holds status for two cycles; only its rising edge is a submission.
  assign sub        = pin_in.status & ~status_q;
  assign pin_digits = {pin_in.digit1, pin_in.digit2, pin_in.digit3, pin_in.digit4};

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    stored_d     = stored_q;
    fail_d       = fail_q;
    grant_d      = 1'b0;
    deny_d       = 1'b0;
    prog_done_d  = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (sub) begin
          cand_d  = pin_digits;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (pin_complete(cand_q) && (cand_q == stored_q)) begin
          grant_d = 1'b1;
          fail_d  = '0;
          if (prog_req) begin
            state_d      = StProgWait;
            tmr_load     = 1'b1;
            tmr_load_val = ProgLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          deny_d = 1'b1;
          if (fail_q < MaxFails) begin
            fail_d = fail_q + 4'd1;
          end
          if (fail_d == MaxFails) begin
            state_d      = StLockout;
            tmr_load     = 1'b1;
            tmr_load_val = LockLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLockout: begin
        if (tmr_zero) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
      StProgWait: begin
        // A submission beats both the abort and the timeout in the same cycle.
        if (sub) begin
          cand_d  = pin_digits;
          state_d = StProgStore;
        end else if (!prog_req || tmr_zero) begin
          state_d = StIdle;
        end
      end
      StProgStore: begin
        if (pin_complete(cand_q)) begin
          stored_d    = cand_q;
          prog_done_d = 1'b1;
        end else begin
          deny_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      status_q    <= 1'b0;
      cand_q      <= '0;
      stored_q    <= DEFAULT_PIN;
      fail_q      <= '0;
      grant_q     <= 1'b0;
      deny_q      <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= pin_in.status;
      cand_q      <= cand_d;
      stored_q    <= stored_d;
      fail_q      <= fail_d;
      grant_q     <= grant_d;
      deny_q      <= deny_d;
      prog_done_q <= prog_done_d;
    end
  end

  pin_down_timer #(
    .WIDTH(TimerW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .zero    (tmr_zero)
  );

  assign grant       = grant_q;
  assign deny        = deny_q;
  assign prog_done   = prog_done_q;
  assign prog_active = (state_q == StProgWait);
  assign locked      = (state_q == StLockout);
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_pin_checker.sv
// Bench for pin_checker: directed scenarios then random submissions, all checked
// every cycle against a timestamp-based reference model.
module tb_pin_checker;
  import pin_checker_pkg::*;

  localparam int unsigned MaxFails    = 3;
  localparam int unsigned LockCycles  = 20;
  localparam int unsigned ProgTimeout = 10;
  localparam logic [15:0] DefPin      = 16'h1234;
  localparam int          MaxCyc      = 12000;

  logic       clk = 1'b0;
  logic       rst;
  pinPac_t    pin_in;
  logic       prog_req;
  logic       grant, deny, prog_done, prog_active, locked;
  logic [3:0] fail_count;

  always #5 clk = ~clk;

  pin_checker #(
    .MAX_FAILS   (MaxFails),
    .LOCK_CYCLES (LockCycles),
    .PROG_TIMEOUT(ProgTimeout),
    .DEFAULT_PIN (DefPin)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .prog_req   (prog_req),
    .grant      (grant),
    .deny       (deny),
    .prog_done  (prog_done),
    .prog_active(prog_active),
    .locked     (locked),
    .fail_count (fail_count)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: events are scheduled at absolute cycle numbers.
  int          exp_pulse[MaxCyc];  // 0 none, 1 grant, 2 deny, 3 prog_done
  int          fail_set[MaxCyc];   // -1 no change, else new fail count from that cycle
  int          m_fail;
  logic [15:0] m_stored, m_cand;
  int          lock_from, lock_until, prog_from, prog_until, pend_chk, pend_st;
  logic        prev_status;

  // Stimulus generator state
  logic [15:0] pin_q[$];
  int          st_left, gap_left;
  bit          rand_gap;
  bit          req_want;

  function automatic bit tb_complete(input logic [15:0] p);
    for (int i = 0; i < 4; i++) begin
      if (p[4*i+:4] == 4'hF) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] pick_pin();
    int          r;
    int          k;
    logic [15:0] p;
    r = $urandom_range(0, 9);
    p = 16'($urandom);
    k = $urandom_range(0, 3);
    if (r <= 2) return m_stored;
    if (r == 3) return DefPin;
    if (r == 4) return 16'h5678;
    if (r <= 6) p[4*k+:4] = 4'hF;
    return p;
  endfunction

  task automatic model_reset();
    m_fail      = 0;
    m_stored    = DefPin;
    m_cand      = '0;
    lock_from   = 0;
    lock_until  = 0;
    prog_from   = 0;
    prog_until  = 0;
    pend_chk    = -1;
    pend_st     = -1;
    prev_status = 1'b0;
    for (int i = 0; i < MaxCyc; i++) begin
      exp_pulse[i] = 0;
      fail_set[i]  = -1;
    end
  endtask

  task automatic run_cycle(input bit do_rst);
    bit          sub, in_prog, in_lock;
    int          nf;
    logic [15:0] p, digits;
    @(negedge clk);
    if (fail_set[cyc] >= 0) m_fail = fail_set[cyc];
    check_eq("grant", grant, exp_pulse[cyc] == 1);
    check_eq("deny", deny, exp_pulse[cyc] == 2);
    check_eq("prog_done", prog_done, exp_pulse[cyc] == 3);
    check_eq("fail_count", fail_count, m_fail);
    check_eq("locked", locked, (cyc >= lock_from) && (cyc < lock_until));
    check_eq("prog_active", prog_active, (cyc >= prog_from) && (cyc < prog_until));
    prog_req = req_want;
    if (do_rst) begin
      rst = 1'b0;
      pin_in.status = 1'b0;
      st_left = 0;
      gap_left = 0;
      pin_q.delete();
      #1;
      check_eq("rst_grant", grant, 0);
      check_eq("rst_deny", deny, 0);
      check_eq("rst_prog_done", prog_done, 0);
      check_eq("rst_prog_active", prog_active, 0);
      check_eq("rst_locked", locked, 0);
      check_eq("rst_fail_count", fail_count, 0);
      model_reset();
      cyc++;
      return;
    end
    rst = 1'b1;

    if (st_left > 0) begin
      pin_in.status = 1'b1;
      st_left--;
    end else if (gap_left > 0) begin
      pin_in.status = 1'b0;
      gap_left--;
    end else if (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      pin_in.digit1 = p[15:12];
      pin_in.digit2 = p[11:8];
      pin_in.digit3 = p[7:4];
      pin_in.digit4 = p[3:0];
      pin_in.status = 1'b1;
      st_left = 1;
      gap_left = rand_gap ? $urandom_range(1, 4) : 2;
    end else begin
      pin_in.status = 1'b0;
    end

    sub         = pin_in.status && !prev_status;
    prev_status = pin_in.status;
    digits      = {pin_in.digit1, pin_in.digit2, pin_in.digit3, pin_in.digit4};
    in_prog     = (cyc >= prog_from) && (cyc < prog_until);
    in_lock     = (cyc >= lock_from) && (cyc < lock_until);

    if (pend_chk == cyc) begin
      if (tb_complete(m_cand) && m_cand == m_stored) begin
        exp_pulse[cyc+1] = 1;
        fail_set[cyc+1]  = 0;
        if (prog_req) begin
          prog_from  = cyc + 1;
          prog_until = cyc + 1 + ProgTimeout;
        end
      end else begin
        nf = (m_fail < MaxFails) ? m_fail + 1 : m_fail;
        exp_pulse[cyc+1] = 2;
        fail_set[cyc+1]  = nf;
        if (nf == MaxFails) begin
          lock_from  = cyc + 1;
          lock_until = cyc + 1 + LockCycles;
          fail_set[lock_until] = 0;
        end
      end
    end
    if (pend_st == cyc) begin
      if (tb_complete(m_cand)) begin
        m_stored = m_cand;
        exp_pulse[cyc+1] = 3;
      end else begin
        exp_pulse[cyc+1] = 2;
      end
    end
    if (in_prog) begin
      if (sub) begin
        m_cand     = digits;
        pend_st    = cyc + 1;
        prog_until = cyc + 1;
      end else if (!prog_req) begin
        prog_until = cyc + 1;
      end
    end else if (sub && !in_lock && pend_chk != cyc && pend_st != cyc) begin
      m_cand   = digits;
      pend_chk = cyc + 1;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) run_cycle(1'b0);
  endtask

  task automatic submit(input logic [15:0] p);
    pin_q.push_back(p);
  endtask

  initial begin
    rst      = 1'b0;
    prog_req = 1'b0;
    req_want = 1'b0;
    pin_in   = '0;
    rand_gap = 1'b0;
    st_left  = 0;
    gap_left = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("init_grant", grant, 0);
    check_eq("init_deny", deny, 0);
    check_eq("init_prog_done", prog_done, 0);
    check_eq("init_prog_active", prog_active, 0);
    check_eq("init_locked", locked, 0);
    check_eq("init_fail_count", fail_count, 0);

    // Correct PIN
    submit(16'h1234);
    run(8);
    // Three failures, a submission ignored during lockout, then recovery
    submit(16'h9999); submit(16'h9999); submit(16'h9999); submit(16'h1234);
    run(46);
    submit(16'h1234);
    run(8);
    // Incomplete packet, then correct PIN clears the count
    submit(16'hF123); submit(16'h1234);
    run(12);
    // PIN change
    req_want = 1'b1;
    submit(16'h1234);
    run(6);
    submit(16'h5678);
    run(6);
    req_want = 1'b0;
    submit(16'h1234); submit(16'h5678);
    run(12);
    // Programming timeout, then rejected new PIN
    req_want = 1'b1;
    submit(16'h5678);
    run(20);
    submit(16'h5678);
    run(4);
    submit(16'hFF12);
    run(8);
    req_want = 1'b0;
    run(2);
    // Reset mid-lockout
    submit(16'h0000); submit(16'h0000); submit(16'h0000);
    run(16);
    run_cycle(1'b1);
    run(2);
    submit(16'h1234);
    run(8);
    // Reset mid-programming
    req_want = 1'b1;
    submit(16'h1234);
    run(5);
    run_cycle(1'b1);
    req_want = 1'b0;
    submit(16'h1234);
    run(8);

    // Random traffic
    rand_gap = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (pin_q.size() == 0 && $urandom_range(0, 5) == 0) submit(pick_pin());
      if ($urandom_range(0, 24) == 0) req_want = ~req_want;
      run_cycle($urandom_range(0, 1499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pin_checker.md
Name: pin_checker

Overview:
- Consumer of the pinPac_t packet produced by the keypad PIN assembler; sits between that assembler and the lock actuator/display logic.
- Detects each new PIN submission, compares it against a stored 4-digit PIN and issues a one-cycle grant or deny pulse.
- Counts consecutive failures and enforces a timed lockout.
- Supports a PIN-change flow: a correct PIN entered while prog_req is high arms storage of the next submitted packet as the new PIN.

Parameters:
- MAX_FAILS, 3: consecutive denials that trigger lockout (range 1..15).
- LOCK_CYCLES, 50_000_000: lockout duration in clk cycles (>=2).
- PROG_TIMEOUT, 250_000_000: clk cycles allowed in PROG_WAIT before it aborts.
- DEFAULT_PIN, 16'h1234: stored PIN after reset; digit1 is in bits [15:12].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- pin_in  in  pinPac_t  digit1..digit4 (4b each) plus status; status is high for exactly 2 consecutive cycles per submission
- prog_req  in  1  level; user requests a PIN change
- grant  out  1  one-cycle pulse; PIN matched
- deny  out  1  one-cycle pulse; PIN mismatched, incomplete, or rejected as a new PIN
- prog_done  out  1  one-cycle pulse; new PIN stored
- prog_active  out  1  level; high in PROG_WAIT
- locked  out  1  level; high in LOCKOUT
- fail_count  out  4  consecutive denial count

Behaviour:
- Reset (rst=0, async): state IDLE; stored PIN = DEFAULT_PIN; all pulses, prog_active and locked = 0; fail_count = 0; status_q = 0; timers = 0.
- Submission edge: sub = pin_in.status & ~status_q, where status_q is pin_in.status registered every cycle. Only the rising edge counts, so the 2-cycle status is one submission.
- On sub in cycle t, latch the four digits into cand. Outputs are registered, so grant, deny or prog_done is visible in cycle t+2.
- A packet is complete only if no digit equals 4'hF. An incomplete packet never matches.
- IDLE:
  - On sub, go to CHECK.
- CHECK:
  - Match (complete and cand == stored): assert grant; fail_count <= 0. If prog_req=1, go to PROG_WAIT; otherwise go to IDLE.
  - Mismatch: assert deny; fail_count++. If the new count equals MAX_FAILS, go to LOCKOUT and load the timer with LOCK_CYCLES-1; otherwise go to IDLE.
- LOCKOUT:
  - locked=1; sub is ignored and produces no pulses; timer decrements each cycle.
  - At timer 0: go to IDLE, locked <= 0, fail_count <= 0.
- PROG_WAIT:
  - prog_active=1; timer runs from PROG_TIMEOUT-1.
  - On sub, go to PROG_STORE.
  - Timer 0 with no sub: go to IDLE silently, stored PIN unchanged.
  - prog_req falling: abort to IDLE the next cycle.
- PROG_STORE:
  - Complete cand: stored <= cand; assert prog_done.
  - Incomplete cand: stored PIN unchanged; assert deny, but do not increment fail_count.
  - Then go to IDLE.
- Simultaneous events:
  - sub in the same cycle as the PROG_WAIT timeout: sub wins.
  - sub while in CHECK or PROG_STORE cannot occur; each of those states lasts one cycle and status needs >=2 cycles plus a gap.
- grant, deny and prog_done are mutually exclusive and never high for 2 consecutive cycles.
- fail_count saturates at MAX_FAILS.
- Reset mid-lockout or mid-program: immediate return to the reset values, including DEFAULT_PIN.

Decomposition:
- Shared package: pinPac_t (existing), the checker state enum, PIN_BLANK_DIGIT = 4'hF, and a pin_complete() function.
- One sub-module, pin_down_timer: loadable down-counter with load, load_val, zero outputs and WIDTH = $clog2 of the max parameter. It is shared by LOCKOUT and PROG_WAIT.

Test Plan:
- Correct PIN: reset, submit 1,2,3,4 with status high 2 cycles -> grant pulses once at edge+2; fail_count=0; deny never asserted.
- Lockout: MAX_FAILS=3, LOCK_CYCLES=20; submit 9,9,9,9 three times -> deny x3, fail_count 1/2/3, locked=1. Submit 1,2,3,4 during lockout -> no pulse. After 20 cycles, locked=0 and fail_count=0; then 1,2,3,4 -> grant.
- Incomplete packet: submit F,1,2,3 -> deny, fail_count=1. Then 1,2,3,4 -> grant and fail_count=0.
- PIN change: prog_req=1; submit 1,2,3,4 -> grant, prog_active=1. Submit 5,6,7,8 -> prog_done. Submit 1,2,3,4 -> deny; submit 5,6,7,8 -> grant.
- Program abort and invalid new PIN:
  - PROG_TIMEOUT=10 with no sub -> prog_active drops after 10 cycles; PIN unchanged.
  - New PIN F,F,1,2 -> deny, fail_count unchanged, PIN unchanged.
- Async reset mid-LOCKOUT and mid-PROG_WAIT: rst low for 1 cycle -> all outputs 0 immediately; PIN = DEFAULT_PIN (1,2,3,4 grants).
